// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared watchdog widths, state encoding and reset-time limits
package wdt_pkg;

  localparam int WIDTH = 4;

  typedef logic [WIDTH-1:0] size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WARN  = 2'd2,
    BITE  = 2'd3
  } state_t;

  localparam size_t DEF_WARN = size_t'(9);
  localparam size_t DEF_BITE = size_t'(5);

endpackage

// File: rtl/wdt_counter.sv
// rtl/wdt_counter.sv - saturating phase counter with limit compare
module wdt_counter
  import wdt_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  // Saturation is only a safeguard: the controller clears on every limit match.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + size_t'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/wdt_ctrl.sv
// rtl/wdt_ctrl.sv - watchdog FSM sequencing arm, warn and bite phases
module wdt_ctrl
  import wdt_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_enable,
  input  logic             i_kick,
  input  logic             i_cfg_we,
  input  logic [WIDTH-1:0] i_warn_lim,
  input  logic [WIDTH-1:0] i_bite_lim,
  output logic [1:0]       o_state,
  output logic [WIDTH-1:0] o_count,
  output logic             o_warn,
  output logic             o_bite,
  output logic             o_cfg_err
);

  state_t state;
  size_t  warn_lim_r;
  size_t  bite_lim_r;
  size_t  limit;
  logic   clear;
  logic   inc;
  logic   at_limit;
  logic   cfg_ok;

  assign cfg_ok = (i_warn_lim != '0) && (i_bite_lim != '0);
  assign limit  = (state == ARMED) ? warn_lim_r : bite_lim_r;

  // The counter only advances on a quiet, enabled, non-matching cycle;
  // every other case in every state restarts the phase at zero.
  always_comb begin
    clear = 1'b1;
    inc   = 1'b0;
    case (state)
      ARMED, WARN: begin
        if (i_enable && !i_kick && !at_limit) begin
          clear = 1'b0;
          inc   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= IDLE;
      warn_lim_r <= DEF_WARN;
      bite_lim_r <= DEF_BITE;
      o_cfg_err  <= 1'b0;
    end else begin
      o_cfg_err <= i_cfg_we && ((state != IDLE) || !cfg_ok);
      if (i_cfg_we && (state == IDLE) && cfg_ok) begin
        warn_lim_r <= i_warn_lim;
        bite_lim_r <= i_bite_lim;
      end
      case (state)
        IDLE: begin
          if (i_enable) state <= ARMED;
        end
        ARMED: begin
          if (!i_enable) state <= IDLE;
          else if (!i_kick && at_limit) state <= WARN;
        end
        WARN: begin
          if (!i_enable) state <= IDLE;
          else if (i_kick) state <= ARMED;
          else if (at_limit) state <= BITE;
        end
        default: state <= BITE;
      endcase
    end
  end

  wdt_counter u_counter (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .clear    (clear),
    .inc      (inc),
    .limit    (limit),
    .count    (o_count),
    .at_limit (at_limit)
  );

  assign o_state = state;
  assign o_warn  = (state == WARN);
  assign o_bite  = (state == BITE);

endmodule
